// File: rtl/blink_meter.sv
// blink_meter: measures edge-to-edge distance of an async square wave,
// reports lock against the nominal half-period and flags a stuck input.
module blink_meter #(
  parameter int CLK_FREQ_KHz = 50000,
  parameter int LED_FREQ_Hz  = 1,
  parameter int HALF_PERIOD  = (CLK_FREQ_KHz*1000)/(LED_FREQ_Hz*2),
  parameter int TOL          = HALF_PERIOD/8,
  parameter int TIMEOUT      = 2*HALF_PERIOD,
  localparam int CW          = $clog2(TIMEOUT+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          blink_in,
  output logic          level,
  output logic [CW-1:0] half_period,
  output logic          period_valid,
  output logic          locked,
  output logic          stuck
);

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    TRACK
  } state_e;

  // tolerance window, lower bound clamped at zero
  localparam int          LO_I  = (HALF_PERIOD > TOL) ? HALF_PERIOD - TOL : 0;
  localparam int          HI_I  = HALF_PERIOD + TOL;
  localparam logic [31:0] LO_C  = 32'(LO_I);
  localparam logic [31:0] HI_C  = 32'(HI_I);
  localparam logic [CW-1:0] TO_C  = CW'(TIMEOUT);
  localparam logic [CW-1:0] TO_M1 = CW'(TIMEOUT - 1);

  logic          s1_q, s2_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    good_q;
  state_e        state_q;
  logic [CW-1:0] half_q;
  logic          pv_q, locked_q, stuck_q;

  logic          det_edge;
  logic [CW-1:0] n_w;
  logic [31:0]   n32;
  logic          in_tol;

  assign det_edge = (s2_q != prev_q);
  assign n_w      = cnt_q + CW'(1);
  assign n32      = 32'(n_w);
  assign in_tol   = (n32 >= LO_C) && (n32 <= HI_C);

  assign level        = s2_q;
  assign half_period  = half_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign stuck        = stuck_q;

  // two-flop synchronizer plus previous-level register for edge detect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= blink_in;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  // cycles since last edge, saturating at TIMEOUT
  always_comb begin
    cnt_d = cnt_q;
    if (det_edge) begin
      cnt_d = '0;
    end else if (cnt_q != TO_C) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // edge-distance counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // search/measure/track FSM with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= SEARCH;
      good_q   <= 2'd0;
      half_q   <= '0;
      pv_q     <= 1'b0;
      locked_q <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      pv_q     <= 1'b0;
      locked_q <= (good_q == 2'd2);
      unique case (state_q)
        SEARCH: begin
          if (det_edge) begin
            state_q <= MEASURE;
            stuck_q <= 1'b0;
          end
        end
        MEASURE, TRACK: begin
          if (det_edge) begin
            half_q  <= n_w;
            pv_q    <= 1'b1;
            state_q <= TRACK;
            if (!in_tol) begin
              good_q <= 2'd0;
            end else if (good_q != 2'd2) begin
              good_q <= good_q + 2'd1;
            end
          end else if (cnt_q == TO_M1) begin
            stuck_q  <= 1'b1;
            locked_q <= 1'b0;
            good_q   <= 2'd0;
            half_q   <= '0;
            state_q  <= SEARCH;
          end
        end
        default: begin
          state_q <= SEARCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blink_meter.sv
// tb_blink_meter: scoreboard bench for blink_meter
// (HALF_PERIOD=10, TOL=1, TIMEOUT=20).
module tb_blink_meter;

  localparam int CW = $clog2(2*10+1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          blink_in = 1'b0;
  logic          level;
  logic [CW-1:0] half_period;
  logic          period_valid;
  logic          locked;
  logic          stuck;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_tog = 0;
  bit searching = 1'b1;
  int exp_q[$];

  blink_meter #(
    .CLK_FREQ_KHz(1),
    .LED_FREQ_Hz (50)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .blink_in    (blink_in),
    .level       (level),
    .half_period (half_period),
    .period_valid(period_valid),
    .locked      (locked),
    .stuck       (stuck)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: every pulse pops one expected distance
  always @(negedge clk) begin : mon
    int e;
    if (rst && period_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse: got half_period=%0d, required no pulse",
                 half_period);
      end else begin
        e = exp_q.pop_front();
        if (int'(half_period) !== e) begin
          n_err++;
          $display("FAIL half_period: got %0d, required %0d", half_period, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  // toggle input hp cycles after the previous toggle; queue the distance
  task automatic tog(input int hp);
    while (cyc < last_tog + hp) @(negedge clk);
    blink_in = ~blink_in;
    if (searching) searching = 1'b0;
    else exp_q.push_back(cyc - last_tog);
    last_tog = cyc;
  endtask

  task automatic wait_pv(output bit got);
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (period_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int pulses;
    #2 rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      blink_in = ~blink_in;
    end
    n_cmp += 5;
    if (level !== 1'b0) begin
      n_err++; $display("FAIL rst_level: got %b, required 0", level);
    end
    if (half_period !== '0) begin
      n_err++; $display("FAIL rst_half: got %0d, required 0", half_period);
    end
    if (period_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_pv: got %b, required 0", period_valid);
    end
    if (locked !== 1'b0) begin
      n_err++; $display("FAIL rst_locked: got %b, required 0", locked);
    end
    if (stuck !== 1'b0) begin
      n_err++; $display("FAIL rst_stuck: got %b, required 0", stuck);
    end
    blink_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    searching = 1'b1;
    last_tog = cyc;
    tog(10);
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (period_valid) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_err++; $display("FAIL first_edge_pulse: got %0d pulses, required 0", pulses);
    end
  endtask

  task automatic test_square;
    bit got;
    tog(10);
    wait_pv(got);
    n_cmp++;
    if (!got) begin
      n_err++; $display("FAIL sq_pv2: got no pulse, required pulse");
    end
    tog(10);
    wait_pv(got);
    n_cmp += 2;
    if (!got) begin
      n_err++; $display("FAIL sq_pv3: got no pulse, required pulse");
    end
    if (locked !== 1'b0) begin
      n_err++; $display("FAIL sq_lock_early: got %b, required 0", locked);
    end
    @(negedge clk);
    n_cmp++;
    if (locked !== 1'b1) begin
      n_err++; $display("FAIL sq_lock: got %b, required 1", locked);
    end
  endtask

  task automatic test_offfreq;
    bit got;
    int hp_tab[5] = '{12, 10, 10, 9, 11};
    bit lk_tab[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      tog(hp_tab[i]);
      wait_pv(got);
      @(negedge clk);
      n_cmp += 2;
      if (!got) begin
        n_err++; $display("FAIL off_pv[%0d]: got no pulse, required pulse", i);
      end
      if (locked !== lk_tab[i]) begin
        n_err++;
        $display("FAIL off_lock[%0d] hp=%0d: got %b, required %b",
                 i, hp_tab[i], locked, lk_tab[i]);
      end
    end
  endtask

  task automatic test_stuck;
    bit got;
    int t0;
    t0 = last_tog;
    while (cyc < t0 + 22) @(negedge clk);
    n_cmp++;
    if (stuck !== 1'b0) begin
      n_err++; $display("FAIL stuck_early: got %b, required 0", stuck);
    end
    @(negedge clk);
    n_cmp += 3;
    if (stuck !== 1'b1) begin
      n_err++; $display("FAIL stuck_set: got %b, required 1", stuck);
    end
    if (locked !== 1'b0) begin
      n_err++; $display("FAIL stuck_locked: got %b, required 0", locked);
    end
    if (half_period !== '0) begin
      n_err++; $display("FAIL stuck_half: got %0d, required 0", half_period);
    end
    searching = 1'b1;
    tog(1);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (stuck !== 1'b0) begin
      n_err++; $display("FAIL stuck_clear: got %b, required 0", stuck);
    end
    tog(10);
    wait_pv(got);
    n_cmp++;
    if (!got) begin
      n_err++; $display("FAIL stuck_pv: got no pulse, required pulse");
    end
    tog(10);
    wait_pv(got);
    @(negedge clk);
    n_cmp++;
    if (locked !== 1'b1) begin
      n_err++; $display("FAIL stuck_relock: got %b, required 1", locked);
    end
  endtask

  task automatic test_glitch;
    bit got;
    tog(10);
    tog(1);
    wait_pv(got);
    wait_pv(got);
    @(negedge clk);
    n_cmp += 2;
    if (!got) begin
      n_err++; $display("FAIL glitch_pv: got no pulse, required pulse");
    end
    if (locked !== 1'b0) begin
      n_err++; $display("FAIL glitch_lock: got %b, required 0", locked);
    end
    tog(10);
    wait_pv(got);
    @(negedge clk);
    n_cmp++;
    if (locked !== 1'b0) begin
      n_err++; $display("FAIL glitch_good1: got %b, required 0", locked);
    end
    tog(10);
    wait_pv(got);
    @(negedge clk);
    n_cmp++;
    if (locked !== 1'b1) begin
      n_err++; $display("FAIL glitch_relock: got %b, required 1", locked);
    end
  endtask

  task automatic test_reset_mid;
    bit got;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp += 4;
    if (locked !== 1'b0) begin
      n_err++; $display("FAIL mid_locked: got %b, required 0", locked);
    end
    if (half_period !== '0) begin
      n_err++; $display("FAIL mid_half: got %0d, required 0", half_period);
    end
    if (level !== 1'b0) begin
      n_err++; $display("FAIL mid_level: got %b, required 0", level);
    end
    if (stuck !== 1'b0) begin
      n_err++; $display("FAIL mid_stuck: got %b, required 0", stuck);
    end
    blink_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    searching = 1'b1;
    last_tog = cyc;
    tog(10);
    tog(10);
    wait_pv(got);
    @(negedge clk);
    n_cmp++;
    if (locked !== 1'b0) begin
      n_err++; $display("FAIL mid_edge2_lock: got %b, required 0", locked);
    end
    tog(10);
    wait_pv(got);
    n_cmp++;
    if (locked !== 1'b0) begin
      n_err++; $display("FAIL mid_edge3_early: got %b, required 0", locked);
    end
    @(negedge clk);
    n_cmp++;
    if (locked !== 1'b1) begin
      n_err++; $display("FAIL mid_relock: got %b, required 1", locked);
    end
  endtask

  initial begin
    test_reset();
    test_square();
    test_offfreq();
    test_stuck();
    test_glitch();
    test_reset_mid();
    repeat (6) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pending: got %0d unmatched, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
